// File: rtl/seq_divider.sv
// Multi-cycle unsigned non-restoring divider with valid/ready request and response ports.
// One add-or-subtract of the divisor per RUN cycle, then a single remainder fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_d;
  logic [WIDTH-1:0]        r_q;
  logic signed [WIDTH:0]   r_r;
  logic [WIDTH-1:0]        r_quot;
  logic [WIDTH-1:0]        r_rem;
  logic                    r_dbz;
  logic signed [WIDTH:0]   w_r_step;
  logic [WIDTH-1:0]        w_rem_fix;
  logic                    w_div_zero;

  // One non-restoring iteration: shift in the next dividend bit, then add or
  // subtract the divisor depending on the sign of the current partial remainder.
  function automatic logic signed [WIDTH:0] nr_step(
    input logic signed [WIDTH:0] r,
    input logic                  q_msb,
    input logic [WIDTH-1:0]      d
  );
    logic signed [WIDTH:0] s;
    logic signed [WIDTH:0] d_ext;
    s     = {r[WIDTH-1:0], q_msb};
    d_ext = {1'b0, d};
    return r[WIDTH] ? (s + d_ext) : (s - d_ext);
  endfunction

  // Final correction: a negative partial remainder gets the divisor added back.
  function automatic logic [WIDTH-1:0] nr_fix(
    input logic signed [WIDTH:0] r,
    input logic [WIDTH-1:0]      d
  );
    return r[WIDTH] ? (r[WIDTH-1:0] + d) : r[WIDTH-1:0];
  endfunction

  assign w_r_step    = nr_step(r_r, r_q[WIDTH-1], r_d);
  assign w_rem_fix   = nr_fix(r_r, r_d);
  assign w_div_zero  = (divisor == '0);
  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_next = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (done_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Control and visible result registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            if (w_div_zero) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_cnt <= CW'(WIDTH - 1);
            end
          end
        end
        S_RUN: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_FIX: begin
          r_quot <= r_q;
          r_rem  <= w_rem_fix;
          r_dbz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: loaded on request, no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start_valid && !w_div_zero) begin
      r_d <= divisor;
      r_q <= dividend;
      r_r <= '0;
    end else if (r_state == S_RUN) begin
      r_r <= w_r_step;
      r_q <= {r_q[WIDTH-2:0], ~w_r_step[WIDTH]};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal expectations plus an
// exhaustive/random sweep compared every cycle against a transaction-level model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending operation, its latency in clocks
  // counted from the request edge, and the result the outputs must show.
  logic         m_on = 1'b0;
  logic         m_busy = 1'b0;
  int           m_age = 0;
  int           m_lat = 0;
  logic [W-1:0] m_pq = '0, m_pr = '0, m_oq = '0, m_or = '0;
  logic         m_pz = 1'b0, m_oz = 1'b0;
  logic         m_dv;

  initial begin
    forever begin
      @(negedge clk);
      m_dv = 1'b0;
      if (m_on) begin
        if (m_busy) m_age++;
        m_dv = m_busy && (m_age >= m_lat);
        if (m_dv && m_age == m_lat) begin
          m_oq = m_pq;
          m_or = m_pr;
          m_oz = m_pz;
        end
        chk("mdl_start_ready", int'(start_ready), int'(!m_busy));
        chk("mdl_done_valid", int'(done_valid), int'(m_dv));
        chk("mdl_quotient", int'(quotient), int'(m_oq));
        chk("mdl_remainder", int'(remainder), int'(m_or));
        chk("mdl_div_by_zero", int'(div_by_zero), int'(m_oz));
      end
      if (rst) begin
        m_on   = 1'b1;
        m_busy = 1'b0;
        m_oq   = '0;
        m_or   = '0;
        m_oz   = 1'b0;
      end else if (m_on) begin
        if (m_dv && done_ready) begin
          m_busy = 1'b0;
        end else if (!m_busy && start_valid) begin
          m_busy = 1'b1;
          m_age  = 0;
          if (divisor == '0) begin
            m_pq  = '1;
            m_pr  = dividend;
            m_pz  = 1'b1;
            m_lat = 1;
          end else begin
            m_pq  = dividend / divisor;
            m_pr  = dividend % divisor;
            m_pz  = 1'b0;
            m_lat = W + 2;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready_timeout", int'(start_ready), 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                        output int lat, output logic [W-1:0] oq, output logic [W-1:0] orr,
                        output logic oz);
    wait_ready();
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = W'($urandom);
    divisor     = W'($urandom);
    lat = 1;
    while (!done_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_timeout", int'(done_valid), 1);
    oq  = quotient;
    orr = remainder;
    oz  = div_by_zero;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [W-1:0] oq, orr;
    logic         oz;

    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);

    run_op(4'd13, 4'd4, 0, lat, oq, orr, oz);
    chk("t1_latency", lat, 6);
    chk("t1_q", int'(oq), 3);
    chk("t1_r", int'(orr), 1);
    chk("t1_dbz", int'(oz), 0);

    run_op(4'd15, 4'd1, 1, lat, oq, orr, oz);
    chk("t2a_q", int'(oq), 15);
    chk("t2a_r", int'(orr), 0);
    run_op(4'd0, 4'd5, 0, lat, oq, orr, oz);
    chk("t2b_q", int'(oq), 0);
    chk("t2b_r", int'(orr), 0);
    run_op(4'd3, 4'd9, 2, lat, oq, orr, oz);
    chk("t2c_q", int'(oq), 0);
    chk("t2c_r", int'(orr), 3);

    run_op(4'd7, 4'd0, 0, lat, oq, orr, oz);
    chk("t3_latency", lat, 1);
    chk("t3_q", int'(oq), 15);
    chk("t3_r", int'(orr), 7);
    chk("t3_dbz", int'(oz), 1);
    run_op(4'd6, 4'd3, 0, lat, oq, orr, oz);
    chk("t3b_q", int'(oq), 2);
    chk("t3b_r", int'(orr), 0);
    chk("t3b_dbz", int'(oz), 0);

    // Backpressure: result held while the consumer stalls, new requests ignored.
    wait_ready();
    start_valid = 1'b1; dividend = 4'd11; divisor = 4'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t4_latency", lat, 6);
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'b1; dividend = 4'd5; divisor = 4'd1;
      @(posedge clk); #1;
      chk("t4_hold_valid", int'(done_valid), 1);
      chk("t4_hold_q", int'(quotient), 3);
      chk("t4_hold_r", int'(remainder), 2);
      chk("t4_start_ready", int'(start_ready), 0);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("t4_release_valid", int'(done_valid), 0);
    chk("t4_release_ready", int'(start_ready), 1);

    // Reset during the second RUN cycle aborts the operation.
    start_valid = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_done_valid", int'(done_valid), 0);
    chk("t5_start_ready", int'(start_ready), 1);
    chk("t5_q", int'(quotient), 0);
    chk("t5_r", int'(remainder), 0);
    chk("t5_dbz", int'(div_by_zero), 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("t5_no_done", int'(done_valid), 0);
    run_op(4'd9, 4'd2, 0, lat, oq, orr, oz);
    chk("t5b_q", int'(oq), 4);
    chk("t5b_r", int'(orr), 1);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(W'(ia), W'(ib), int'($urandom_range(0, 3)), lat, oq, orr, oz);
        if (ib == 0) begin
          chk("sweep_q", int'(oq), 15);
          chk("sweep_r", int'(orr), ia);
          chk("sweep_dbz", int'(oz), 1);
          chk("sweep_lat", lat, 1);
        end else begin
          chk("sweep_q", int'(oq), ia / ib);
          chk("sweep_r", int'(orr), ia % ib);
          chk("sweep_dbz", int'(oz), 0);
          chk("sweep_lat", lat, W + 2);
        end
      end
    end

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(W'($urandom), W'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
             lat, oq, orr, oz);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
